// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch-stage program counter with branch/jump redirect,
// one-cycle squash FSM covering instruction-memory latency, and a
// saturating taken-branch counter.
// Optional feature: define MISALIGN_TRAP_EN to trap redirects whose
// target is not word-aligned (pc <- TRAP_VECTOR, misalign_trap pulse).
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   RUN    | instruction-memory output is a valid fetch (if_valid = 1)
//   SQUASH | first cycle after reset or a pc redirect; fetch invalid
module pc_redirect_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic        ex_branch,
  input  logic        branch,
  input  logic        ex_jump,
  input  logic [31:0] ex_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        if_valid,
  output logic        flush,
  output logic        misalign_trap,
  output logic [15:0] br_taken_cnt
);

  typedef enum logic {RUN = 1'b0, SQUASH = 1'b1} state_t;

  state_t      state_q, state_d;
  // Only the word index is stored, so pc cannot become misaligned.
  logic [29:0] pc_q, pc_d;
  logic [15:0] cnt_q, cnt_d;

  logic        redirect;
  logic        br_taken;
  logic        misalign;
  logic [29:0] target_word;

  assign redirect    = ex_valid & (ex_jump | (ex_branch & branch));
  assign br_taken    = ex_valid & ex_branch & branch;
  assign target_word = ex_target[31:2];

`ifdef MISALIGN_TRAP_EN
  assign misalign = redirect & (ex_target[1:0] != 2'b00);
  logic unused_bits;
  assign unused_bits = ^{RESET_VECTOR[1:0], TRAP_VECTOR[1:0]};
`else
  assign misalign = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{RESET_VECTOR[1:0], TRAP_VECTOR, ex_target[1:0]};
`endif

  assign pc            = {pc_q, 2'b00};
  assign pc_plus4      = {pc_q + 30'd1, 2'b00};
  assign br_taken_cnt  = cnt_q;
  // Gated by RST so nothing leaks out while the unit is held in reset.
  assign flush         = redirect & ~RST;
  assign misalign_trap = misalign & ~RST;

  // Next pc: redirect (or trap) beats stall, stall beats sequential advance.
  always_comb begin
    pc_d = pc_q + 30'd1;
    if (misalign) begin
      pc_d = TRAP_VECTOR[31:2];
    end else if (redirect) begin
      pc_d = target_word;
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  // Saturating count of taken conditional branches; jumps are not counted.
  always_comb begin
    cnt_d = cnt_q;
    if (br_taken && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // FSM next state and fetch-valid output.
  always_comb begin
    state_d  = state_q;
    if_valid = 1'b0;
    case (state_q)
      RUN: begin
        if_valid = 1'b1;
        if (redirect) state_d = SQUASH;
      end
      SQUASH: begin
        state_d = redirect ? SQUASH : RUN;
      end
      default: state_d = SQUASH;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= SQUASH;
      pc_q    <= RESET_VECTOR[31:2];
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed-vector bench for pc_redirect_unit.
module tb_pc_redirect_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        stall, ex_valid, ex_branch, branch, ex_jump;
  logic [31:0] ex_target;
  logic [31:0] pc, pc_plus4;
  logic        if_valid, flush, misalign_trap;
  logic [15:0] br_taken_cnt;

  int n_cmp = 0;
  int n_err = 0;

  pc_redirect_unit dut (
    .CLK(CLK), .RST(RST), .stall(stall), .ex_valid(ex_valid),
    .ex_branch(ex_branch), .branch(branch), .ex_jump(ex_jump),
    .ex_target(ex_target), .pc(pc), .pc_plus4(pc_plus4),
    .if_valid(if_valid), .flush(flush), .misalign_trap(misalign_trap),
    .br_taken_cnt(br_taken_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    stall = 0; ex_valid = 0; ex_branch = 0; branch = 0; ex_jump = 0;
    ex_target = 32'h0;
  endtask

  initial begin
    idle();
    RST = 1'b1;
    // reset overrides a simultaneous redirect
    ex_valid = 1; ex_jump = 1; ex_target = 32'h40;
    tick(); tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_ifv", {31'b0, if_valid}, 32'h0);
    chk("rst_flush", {31'b0, flush}, 32'h0);
    chk("rst_trap", {31'b0, misalign_trap}, 32'h0);
    chk("rst_cnt", {16'b0, br_taken_cnt}, 32'h0);
    idle();
    RST = 1'b0;
    #1;
    // first free cycle is SQUASH
    chk("c0_pc", pc, 32'h0);
    chk("c0_ifv", {31'b0, if_valid}, 32'h0);
    chk("c0_pc4", pc_plus4, 32'h4);
    tick(); chk("c1_pc", pc, 32'h4); chk("c1_ifv", {31'b0, if_valid}, 32'h1);
    tick(); chk("c2_pc", pc, 32'h8); chk("c2_ifv", {31'b0, if_valid}, 32'h1);
    tick(); chk("c3_pc", pc, 32'hC); chk("c3_ifv", {31'b0, if_valid}, 32'h1);

    // taken branch with simultaneous stall: redirect wins
    ex_valid = 1; ex_branch = 1; branch = 1; ex_target = 32'h200; stall = 1;
    #1; chk("br_flush", {31'b0, flush}, 32'h1);
    tick(); idle(); #1;
    chk("br_pc", pc, 32'h200);
    chk("br_ifv", {31'b0, if_valid}, 32'h0);
    chk("br_cnt", {16'b0, br_taken_cnt}, 32'h1);
    chk("br_flush_off", {31'b0, flush}, 32'h0);
    tick(); chk("br_pc2", pc, 32'h204); chk("br_ifv2", {31'b0, if_valid}, 32'h1);

    // plain stall holds pc
    stall = 1; tick(); chk("stall_pc", pc, 32'h204); stall = 0;

    // not-taken branch
    ex_valid = 1; ex_branch = 1; branch = 0; ex_target = 32'h500;
    #1; chk("nt_flush", {31'b0, flush}, 32'h0);
    tick(); chk("nt_pc", pc, 32'h208); chk("nt_cnt", {16'b0, br_taken_cnt}, 32'h1);
    chk("nt_ifv", {31'b0, if_valid}, 32'h1);

    // bubble with branch asserted
    ex_valid = 0; ex_branch = 1; branch = 1; ex_jump = 1;
    #1; chk("bub_flush", {31'b0, flush}, 32'h0);
    tick(); chk("bub_pc", pc, 32'h20C); chk("bub_cnt", {16'b0, br_taken_cnt}, 32'h1);
    idle();

    // jump to last word, not counted, then wrap
    ex_valid = 1; ex_jump = 1; ex_target = 32'hFFFF_FFFC;
    #1; chk("jmp_flush", {31'b0, flush}, 32'h1);
    tick(); idle(); #1;
    chk("jmp_pc", pc, 32'hFFFF_FFFC);
    chk("jmp_cnt", {16'b0, br_taken_cnt}, 32'h1);
    chk("jmp_ifv", {31'b0, if_valid}, 32'h0);
    chk("wrap_pc4", pc_plus4, 32'h0);
    tick(); chk("wrap_pc", pc, 32'h0); chk("wrap_ifv", {31'b0, if_valid}, 32'h1);

    // misaligned jump target
    ex_valid = 1; ex_jump = 1; ex_target = 32'h202;
    #1;
`ifdef MISALIGN_TRAP_EN
    chk("mis_trap", {31'b0, misalign_trap}, 32'h1);
`else
    chk("mis_trap", {31'b0, misalign_trap}, 32'h0);
`endif
    chk("mis_flush", {31'b0, flush}, 32'h1);
    tick();
`ifdef MISALIGN_TRAP_EN
    chk("mis_pc", pc, 32'h100);
`else
    chk("mis_pc", pc, 32'h200);
`endif
    // redirect again while in SQUASH
    ex_target = 32'h300;
    tick(); idle(); #1;
    chk("sq_pc", pc, 32'h300);
    chk("sq_ifv", {31'b0, if_valid}, 32'h0);
    tick(); chk("sq_pc2", pc, 32'h304); chk("sq_ifv2", {31'b0, if_valid}, 32'h1);

    // asynchronous reset mid-stall
    stall = 1; ex_valid = 1; ex_jump = 1; ex_target = 32'h800;
    #2; RST = 1'b1; #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_cnt", {16'b0, br_taken_cnt}, 32'h0);
    chk("arst_ifv", {31'b0, if_valid}, 32'h0);
    chk("arst_flush", {31'b0, flush}, 32'h0);
    tick(); idle(); RST = 1'b0; #1;
    chk("arst_c0", {31'b0, if_valid}, 32'h0);
    tick(); chk("arst_c1_pc", pc, 32'h4); chk("arst_c1_ifv", {31'b0, if_valid}, 32'h1);

    // counter saturation
    ex_valid = 1; ex_branch = 1; branch = 1; ex_target = 32'h200;
    for (int i = 0; i < 65534; i++) tick();
    chk("sat_fffe", {16'b0, br_taken_cnt}, 32'hFFFE);
    tick(); chk("sat_ffff", {16'b0, br_taken_cnt}, 32'hFFFF);
    tick(); chk("sat_hold1", {16'b0, br_taken_cnt}, 32'hFFFF);
    tick(); tick(); chk("sat_hold2", {16'b0, br_taken_cnt}, 32'hFFFF);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, the PC loaded on reset.
REQ-002 SHALL have parameter TRAP_VECTOR, default 32'h0000_0100, the PC loaded on a misaligned-target trap (used only under MISALIGN_TRAP_EN).
REQ-003 SHALL have port CLK  in  1  pipeline clock; all state updates on the rising edge.
REQ-004 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port stall  in  1  hazard-unit hold request for the fetch stage.
REQ-006 SHALL have port ex_valid  in  1  EX stage holds a live (non-bubble) instruction.
REQ-007 SHALL have port ex_branch  in  1  EX instruction is a conditional branch.
REQ-008 SHALL have port branch  in  1  branch-taken decision from the EX branch condition generator.
REQ-009 SHALL have port ex_jump  in  1  EX instruction is JAL or JALR.
REQ-010 SHALL have port ex_target  in  32  branch/jump target computed in EX.
REQ-011 SHALL have port pc  out  32  current fetch address, which drives the synchronous instruction memory.
REQ-012 SHALL have port pc_plus4  out  32  pc + 4, modulo 2^32.
REQ-013 SHALL have port if_valid  out  1  instruction-memory output this cycle is a valid fetch.
REQ-014 SHALL have port flush  out  1  squash the IF/ID and ID/EX registers.
REQ-015 SHALL have port misalign_trap  out  1  misaligned-target trap pulse.
REQ-016 SHALL have port br_taken_cnt  out  16  count of taken conditional branches.

Function
REQ-017 SHALL compute redirect = ex_valid & (ex_jump | (ex_branch & branch)).
REQ-018 SHALL compute next pc with priority: redirect -> target; else stall -> hold pc; else pc + 4.
- A redirect overrides a simultaneous stall.
REQ-019 SHALL wrap pc from 32'hFFFF_FFFC to 32'h0000_0000, with no flag raised.
REQ-020 SHALL assert flush combinationally in the same cycle as redirect, and deassert it otherwise.
REQ-021 SHALL implement an FSM with states RUN and SQUASH.
- RUN -> SQUASH on redirect; otherwise stay in RUN.
- SQUASH -> RUN after exactly one cycle, regardless of stall.
- SQUASH -> SQUASH if redirect is asserted while in SQUASH.
REQ-022 SHALL drive if_valid = 1 in RUN and if_valid = 0 in SQUASH, covering the one-cycle memory latency after a PC change.
REQ-023 SHALL increment br_taken_cnt by 1 per cycle with ex_valid & ex_branch & branch, and SHALL NOT count jumps.
- The counter saturates at 16'hFFFF.
REQ-024 SHALL ignore branch when ex_branch = 0 or ex_valid = 0.
REQ-025 SHALL keep pc word-aligned.

Reset
REQ-026 SHALL, while RST = 1, asynchronously force:
- pc = RESET_VECTOR;
- state = SQUASH;
- br_taken_cnt = 0.
REQ-027 SHALL hold if_valid = 0, flush = 0 and misalign_trap = 0 during reset.
- The first cycle after RST deasserts is SQUASH, so if_valid = 0.
- The second cycle is RUN, with pc = RESET_VECTOR + 4 unless stalled.
REQ-028 SHALL let a reset asserted mid-redirect or mid-stall override all other inputs.

Configuration
REQ-029 SHALL, with macro MISALIGN_TRAP_EN defined, treat redirect with ex_target[1:0] != 2'b00 as a trap:
- misalign_trap = 1 combinationally in that cycle;
- flush = 1;
- next pc = TRAP_VECTOR;
- FSM -> SQUASH;
- br_taken_cnt is still counted for a conditional branch.
REQ-030 SHALL, without MISALIGN_TRAP_EN:
- tie misalign_trap to 0;
- load redirect targets as {ex_target[31:2], 2'b00}.

Verification
REQ-031 SHALL cover: RST pulse, then 4 free cycles -> if_valid 0,1,1,1; pc 0x0, 0x4, 0x8, 0xC.
REQ-032 SHALL cover: ex_valid = 1, ex_branch = 1, branch = 1, ex_target = 0x200, stall = 1 -> flush = 1 that cycle; next pc = 0x200; if_valid = 0 for one cycle; br_taken_cnt + 1.
REQ-033 SHALL cover: ex_branch = 1, branch = 0 (and separately ex_valid = 0, branch = 1) -> no flush; pc advances by 4; counter unchanged.
REQ-034 SHALL cover: pc = 0xFFFF_FFFC, no stall -> next pc = 0x0000_0000.
REQ-035 SHALL cover: 65,536 taken branches -> br_taken_cnt = 0xFFFF and held there on further taken branches.
REQ-036 SHALL cover: with MISALIGN_TRAP_EN, ex_jump = 1, ex_target = 0x202 -> misalign_trap = 1, flush = 1, next pc = 0x100.
- Same stimulus without the macro -> next pc = 0x200, misalign_trap = 0.
